output_pack_mem: RTL

//  Stage directly upstream of the output fetch stage. Accepts the 8-bit result pixel stream from the compute

---
 rtl/output_pack_mem_if.sv | 30 +++
 rtl/output_pack_mem.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/output_pack_mem_if.sv
// Pixel-in / write-out bundle for output_pack_mem. The compute side drives through
// master; the packer sits on slave.
interface output_pack_mem_if #(
  parameter int ADDR_W = 16
);
  logic              frame_start;
  logic              pixel_valid;
  logic [7:0]        pixel_data;
  logic              pixel_last;
  logic [ADDR_W-1:0] WriteAddress;
  logic [127:0]      WriteBus;
  logic              WriteEnable;
  logic              write_bank;
  logic              read_bank;
  logic              busy;
  logic              frame_done;
  logic              overflow;

  modport master (
    output frame_start, pixel_valid, pixel_data, pixel_last,
    input  WriteAddress, WriteBus, WriteEnable, write_bank, read_bank,
           busy, frame_done, overflow
  );

  modport slave (
    input  frame_start, pixel_valid, pixel_data, pixel_last,
    output WriteAddress, WriteBus, WriteEnable, write_bank, read_bank,
           busy, frame_done, overflow
  );
endinterface

// File: rtl/output_pack_mem.sv
// Packs 16 result bytes per 128-bit word into a double-buffered output memory.
// Define OUTPUT_PACK_FLUSH_EN to let pixel_last end a frame early with a zero-padded partial word.
module output_pack_mem_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ld,
  input  logic             clr,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] q,
  output logic [VEC_W-1:0] nxt
);
  always_comb nxt = ld ? din : (clr ? '0 : q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else          q <= nxt;
  end
endmodule

module output_pack_mem #(
  parameter int WORDS_PER_FRAME = 19200,
  parameter int ADDR_W          = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  output_pack_mem_if.slave bus
);
  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 8;
  localparam int CNT_W     = $clog2(NUM_LANES);
  localparam int WCNT_W    = ADDR_W - 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_FRAME - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PACK  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
`ifdef OUTPUT_PACK_FLUSH_EN
  localparam logic [1:0] FLUSH = 2'd3;
`endif

  logic [1:0]                       state_q, state_d;
  logic [CNT_W-1:0]                 byte_cnt_q, byte_cnt_d;
  logic [WCNT_W-1:0]                word_cnt_q, word_cnt_d;
  logic                             bank_q, bank_d;
  logic                             ovf_q, ovf_d;
  logic                             we_q, we_d;
  logic                             done_q, done_d;
  logic [NUM_LANES*VEC_W-1:0]       bus_q, bus_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;

  logic                             acc;
  logic [CNT_W-1:0]                 idx;
  logic [NUM_LANES-1:0]             lane_ld, lane_clr;
  logic [NUM_LANES-1:0][VEC_W-1:0]  asm_q, asm_nxt;

  // A byte is taken in PACK, or in IDLE when frame_start arrives in the same cycle.
  always_comb begin
    acc = bus.pixel_valid &&
          ((state_q == PACK) || ((state_q == IDLE) && bus.frame_start));
    idx = (state_q == PACK) ? byte_cnt_q : '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_ld[k]  = acc && (idx == CNT_W'(k));
      // Starting a word wipes the stale upper bytes so a flushed partial word reads zero there.
      lane_clr[k] = acc && (idx == '0) && (k != 0);
    end
  end

  output_pack_mem_lane #(.VEC_W(VEC_W)) u_lane [NUM_LANES-1:0] (
    .clock   (clock),
    .reset_n (reset_n),
    .ld      (lane_ld),
    .clr     (lane_clr),
    .din     (bus.pixel_data),
    .q       (asm_q),
    .nxt     (asm_nxt)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    bank_d     = bank_q;
    ovf_d      = ovf_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    bus_d      = bus_q;
    addr_d     = addr_q;

    if (bus.pixel_valid && !acc) ovf_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d    = PACK;
          word_cnt_d = '0;
          ovf_d      = 1'b0;
          byte_cnt_d = bus.pixel_valid ? CNT_W'(1) : '0;
        end
      end
      PACK: begin
        if (bus.pixel_valid) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == '1) begin
            we_d       = 1'b1;
            bus_d      = asm_nxt;
            addr_d     = {bank_q, word_cnt_q};
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == LAST_WORD) state_d = DONE;
`ifdef OUTPUT_PACK_FLUSH_EN
            else if (bus.pixel_last) state_d = DONE;
`endif
          end
`ifdef OUTPUT_PACK_FLUSH_EN
          else if (bus.pixel_last) state_d = FLUSH;
`endif
        end
      end
`ifdef OUTPUT_PACK_FLUSH_EN
      FLUSH: begin
        we_d       = 1'b1;
        bus_d      = asm_q;
        addr_d     = {bank_q, word_cnt_q};
        word_cnt_d = word_cnt_q + 1'b1;
        state_d    = DONE;
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        bank_d  = ~bank_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      bank_q     <= 1'b0;
      ovf_q      <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      bus_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      bank_q     <= bank_d;
      ovf_q      <= ovf_d;
      we_q       <= we_d;
      done_q     <= done_d;
      bus_q      <= bus_d;
      addr_q     <= addr_d;
    end
  end

  assign bus.WriteAddress = addr_q;
  assign bus.WriteBus     = bus_q;
  assign bus.WriteEnable  = we_q;
  assign bus.write_bank   = bank_q;
  assign bus.read_bank    = ~bank_q;
  assign bus.frame_done   = done_q;
  assign bus.overflow     = ovf_q;
`ifdef OUTPUT_PACK_FLUSH_EN
  assign bus.busy         = (state_q == PACK) || (state_q == FLUSH);
`else
  assign bus.busy         = (state_q == PACK);
  logic unused_last;
  assign unused_last      = bus.pixel_last;
`endif
endmodule
